// File: rtl/control_pkg.sv
// Shared constants and types for the control-unit dispatcher.
// Holds the FSM class indices, default claim masks and the sequencer state encoding.
package control_pkg;

  localparam int unsigned N_FSM_DEF   = 4;
  localparam int unsigned CTRL_W_DEF  = 24;
  localparam int unsigned TIMEOUT_DEF = 15;

  localparam int unsigned FSM_LS  = 0;
  localparam int unsigned FSM_ALU = 1;
  localparam int unsigned FSM_BR  = 2;
  localparam int unsigned FSM_FP  = 3;

  localparam logic [31:0] MASK0_DEF = 32'h0000_2101;
  localparam logic [31:0] MASK1_DEF = 32'h0000_1EFE;
  localparam logic [31:0] MASK2_DEF = 32'h000F_C000;
  localparam logic [31:0] MASK3_DEF = 32'hFFF0_0000;

  typedef enum logic [2:0] {
    StIdle,
    StDispatch,
    StRun,
    StRetire,
    StFault
  } state_e;

endpackage

// File: rtl/priority_grant.sv
// Lowest-index-wins priority encoder: one-hot grant, binary index and an empty flag.
module priority_grant #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   grant_o,
  output logic [IdW-1:0] id_o,
  output logic           none_valid_o
);

  always_comb begin
    grant_o      = '0;
    id_o         = '0;
    none_valid_o = ~|req_i;
    // Scan downwards so the lowest requester is the last (winning) assignment.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        id_o       = IdW'(i);
      end
    end
  end

endmodule

// File: rtl/control_dispatcher.sv
// Control-unit sequencer: routes each decoded instruction to one class FSM, forwards
// its control bundle while it runs, counts retirements and traps illegal codes or hangs.
module control_dispatcher
  import control_pkg::*;
#(
  parameter int unsigned N_FSM   = N_FSM_DEF,
  parameter int unsigned CTRL_W  = CTRL_W_DEF,
  parameter logic [31:0] MASK0   = MASK0_DEF,
  parameter logic [31:0] MASK1   = MASK1_DEF,
  parameter logic [31:0] MASK2   = MASK2_DEF,
  parameter logic [31:0] MASK3   = MASK3_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  localparam int unsigned IdW    = (N_FSM > 1) ? $clog2(N_FSM) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [31:0]             code_i,
  input  logic                    decode_valid_i,
  input  logic [N_FSM*CTRL_W-1:0] fsm_ctrl_i,
  input  logic [N_FSM-1:0]        fsm_done_i,
  output logic [N_FSM-1:0]        fsm_start_o,
  output logic [CTRL_W-1:0]       ctrl_out_o,
  output logic [IdW-1:0]          active_id_o,
  output logic                    busy_o,
  output logic                    retire_o,
  output logic                    illegal_o,
  output logic                    timeout_err_o,
  output logic [63:0]             instret_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [3:0][31:0] MaskTab = {MASK3, MASK2, MASK1, MASK0};

  state_e            state_q, state_d;
  logic [31:0]       code_q, code_d;
  logic [IdW-1:0]    id_q, id_d;
  logic [N_FSM-1:0]  start_q, start_d;
  logic [CntW-1:0]   run_cnt_q, run_cnt_d;
  logic              retire_q, retire_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic [63:0]       instret_q, instret_d;

  logic [N_FSM-1:0]  claim;
  logic [N_FSM-1:0]  grant_oh;
  logic [IdW-1:0]    grant_id;
  logic              none_claim;

  for (genvar i = 0; i < N_FSM; i++) begin : g_claim
    if (i < 4) begin : g_mask
      assign claim[i] = |(code_q & MaskTab[i]);
    end else begin : g_nomask
      assign claim[i] = 1'b0;
    end
  end

  priority_grant #(
    .N   (N_FSM),
    .IdW (IdW)
  ) u_grant (
    .req_i        (claim),
    .grant_o      (grant_oh),
    .id_o         (grant_id),
    .none_valid_o (none_claim)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      code_q    <= '0;
      id_q      <= '0;
      start_q   <= '0;
      run_cnt_q <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      id_q      <= id_d;
      start_q   <= start_d;
      run_cnt_q <= run_cnt_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    id_d      = id_q;
    start_d   = '0;
    run_cnt_d = run_cnt_q;
    retire_d  = 1'b0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    instret_d = instret_q;
    unique case (state_q)
      StIdle: begin
        if (decode_valid_i) begin
          code_d  = code_i;
          state_d = StDispatch;
        end
      end
      StDispatch: begin
        run_cnt_d = '0;
        if (none_claim) begin
          illegal_d = 1'b1;
          state_d   = StFault;
        end else begin
          id_d    = grant_id;
          start_d = grant_oh;
          state_d = StRun;
        end
      end
      StRun: begin
        // Done wins even on the last allowed cycle.
        if (fsm_done_i[id_q]) begin
          state_d = StRetire;
        end else if (run_cnt_q == CntW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StFault;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      StRetire: begin
        retire_d  = 1'b1;
        instret_d = instret_q + 64'd1;
        state_d   = StIdle;
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    ctrl_out_o = '0;
    if (state_q == StRun) begin
      ctrl_out_o = fsm_ctrl_i[int'(id_q) * CTRL_W +: CTRL_W];
    end
    busy_o = (state_q == StDispatch) || (state_q == StRun) || (state_q == StRetire);
  end

  assign fsm_start_o   = start_q;
  assign active_id_o   = id_q;
  assign retire_o      = retire_q;
  assign illegal_o     = illegal_q;
  assign timeout_err_o = timeout_q;
  assign instret_o     = instret_q;

endmodule

// File: tb/tb_control_dispatcher.sv
// Scoreboard bench for control_dispatcher: stimulus queues timed expected events,
// a negedge monitor pops and compares them, and a small model plays the class FSMs.
module tb_control_dispatcher;
  import control_pkg::*;

  localparam int unsigned NF = 4;
  localparam int unsigned CW = 24;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     code;
  logic            dv;
  logic [NF*CW-1:0] fsm_ctrl;
  logic [NF-1:0]   fsm_done;
  logic [NF-1:0]   fsm_start;
  logic [CW-1:0]   ctrl_out;
  logic [1:0]      active_id;
  logic            busy, retire, illegal, timeout_err;
  logic [63:0]     instret;

  control_dispatcher u_dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .code_i         (code),
    .decode_valid_i (dv),
    .fsm_ctrl_i     (fsm_ctrl),
    .fsm_done_i     (fsm_done),
    .fsm_start_o    (fsm_start),
    .ctrl_out_o     (ctrl_out),
    .active_id_o    (active_id),
    .busy_o         (busy),
    .retire_o       (retire),
    .illegal_o      (illegal),
    .timeout_err_o  (timeout_err),
    .instret_o      (instret)
  );

  always #5 clk = ~clk;

  typedef enum int {EvStart, EvRetire, EvIllegal, EvTimeout} ev_e;
  typedef struct {
    ev_e         kind;
    logic [63:0] val;
    int          cyc;
  } ev_t;

  ev_t         sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          dly[NF];
  int          rem[NF];
  int          spur_cyc = -1;
  logic [NF-1:0] spur_mask = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CW-1:0] slice_of(int i);
    return 24'h3C0000 | 24'(i + 1);
  endfunction

  task automatic push(ev_e k, logic [63:0] v, int c);
    sb.push_back(ev_t'{kind: k, val: v, cyc: c});
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Class FSM model: done arrives dly[i] cycles after that FSM's start pulse.
  initial begin
    logic [NF-1:0] done_v;
    for (int i = 0; i < int'(NF); i++) rem[i] = -1;
    fsm_done = '0;
    forever begin
      @(posedge clk);
      #1;
      done_v = '0;
      for (int i = 0; i < int'(NF); i++) begin
        if (reset === 1'b1) rem[i] = -1;
        else if (fsm_start[i] === 1'b1) rem[i] = dly[i];
        else if (rem[i] > 0) rem[i] = rem[i] - 1;
        else if (rem[i] == 0) rem[i] = -1;
        done_v[i] = (rem[i] == 0) || (spur_mask[i] && cyc == spur_cyc);
      end
      fsm_done = done_v;
    end
  end

  // Monitor: every observed event must match the head of the scoreboard.
  initial begin
    logic          ill_prev;
    logic          to_prev;
    logic [CW-1:0] allowed;
    ev_t           e;
    ill_prev = 1'b0;
    to_prev  = 1'b0;
    allowed  = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int k = 0; k < 4; k++) begin
          ev_e         kind;
          logic [63:0] v;
          bit          hit;
          kind = ev_e'(k);
          hit  = 1'b0;
          v    = '0;
          case (kind)
            EvStart:   begin hit = (fsm_start !== '0); v = {58'd0, active_id, fsm_start}; end
            EvRetire:  begin hit = (retire === 1'b1);  v = instret; end
            EvIllegal: hit = (illegal === 1'b1) && !ill_prev;
            default:   hit = (timeout_err === 1'b1) && !to_prev;
          endcase
          if (hit) begin
            checks++;
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL unexpected_%s: got value %0h at cycle %0d, required no event",
                       kind.name(), v, cyc);
            end else begin
              e = sb.pop_front();
              if (e.kind != kind || e.val !== v || e.cyc != cyc) begin
                failures++;
                $display("FAIL event_%s: got %s=%0h at cycle %0d, required %s=%0h at cycle %0d",
                         e.kind.name(), kind.name(), v, cyc, e.kind.name(), e.val, e.cyc);
              end
              if (e.kind == EvStart) allowed = slice_of(int'(e.val[5:4]));
            end
          end
        end
        ill_prev = illegal;
        to_prev  = timeout_err;
        checks++;
        if (ctrl_out !== '0 && ctrl_out !== allowed) begin
          failures++;
          $display("FAIL ctrl_out: got %0h required 0 or %0h at cycle %0d", ctrl_out, allowed, cyc);
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    dv    = 1'b0;
    code  = '0;
    for (int i = 0; i < int'(NF); i++) begin
      dly[i] = -1;
      fsm_ctrl[i*CW +: CW] = slice_of(i);
    end
    step(3);
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("rst_start", fsm_start, 0);
    chk("rst_ctrl", ctrl_out, 0);
    chk("rst_id", active_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_retire", retire, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_instret", instret, 0);

    // Load: FSM0, done 4 cycles after start.
    dly[0] = 4; code = 32'h0000_0001; dv = 1'b1; n = cyc;
    push(EvStart, 64'h01, n + 2);
    push(EvRetire, 64'd1, n + 8);
    step(1); dv = 1'b0;
    chk("busy_dispatch", busy, 1);
    step(2);
    chk("ctrl_run_ls", ctrl_out, slice_of(0));
    step(5);
    chk("busy_after_retire", busy, 0);
    chk("instret_1", instret, 1);
    step(1);

    // Priority: FSM0 and FSM1 both claim; FSM0 wins.
    dly[0] = 3; code = 32'h0000_2002; dv = 1'b1; n = cyc;
    push(EvStart, 64'h01, n + 2);
    push(EvRetire, 64'd2, n + 7);
    step(1); dv = 1'b0;
    step(7);

    // Spurious FSM3 done during FSM1 run, then back-to-back float op.
    dly[1] = 5; dly[3] = 2; code = 32'h0000_0002; dv = 1'b1; n = cyc;
    spur_mask = 4'b1000; spur_cyc = n + 4;
    push(EvStart, 64'h12, n + 2);
    push(EvRetire, 64'd3, n + 9);
    push(EvStart, 64'h38, n + 11);
    push(EvRetire, 64'd4, n + 15);
    step(1); code = 32'h0010_0000;
    step(9); dv = 1'b0;
    step(6);
    chk("instret_4", instret, 4);

    // Timeout: FSM2 never finishes.
    code = 32'h0000_4000; dv = 1'b1; n = cyc;
    push(EvStart, 64'h24, n + 2);
    push(EvTimeout, 64'd0, n + 17);
    step(1); dv = 1'b0;
    step(17);
    code = 32'h0000_0001; dv = 1'b1;
    step(4);
    chk("fault_timeout_sticky", timeout_err, 1);
    chk("fault_busy", busy, 0);
    chk("fault_instret", instret, 4);
    dv = 1'b0; reset = 1'b1;
    step(1); reset = 1'b0;
    chk("rst2_timeout", timeout_err, 0);
    chk("rst2_instret", instret, 0);

    // Illegal: nobody claims code 0; later decodes are ignored.
    code = 32'h0; dv = 1'b1; n = cyc;
    push(EvIllegal, 64'd0, n + 2);
    step(1); code = 32'h0000_0001;
    step(5);
    chk("illegal_sticky", illegal, 1);
    chk("illegal_busy", busy, 0);
    chk("illegal_ctrl", ctrl_out, 0);
    dv = 1'b0; reset = 1'b1;
    step(1); reset = 1'b0;
    chk("rst3_illegal", illegal, 0);

    // Short FSM0 op (lui bit) so the next reset has a count to clear.
    dly[0] = 1; code = 32'h0000_0100; dv = 1'b1; n = cyc;
    push(EvStart, 64'h01, n + 2);
    push(EvRetire, 64'd1, n + 5);
    step(1); dv = 1'b0;
    step(5);
    chk("instret_short", instret, 1);

    // Reset mid-RUN on FSM2.
    code = 32'h0000_4000; dv = 1'b1; n = cyc;
    push(EvStart, 64'h24, n + 2);
    step(1); dv = 1'b0;
    step(3);
    chk("midrun_busy", busy, 1);
    reset = 1'b1;
    step(1); reset = 1'b0;
    chk("midrun_start", fsm_start, 0);
    chk("midrun_ctrl", ctrl_out, 0);
    chk("midrun_id", active_id, 0);
    chk("midrun_busy_after", busy, 0);
    chk("midrun_retire", retire, 0);
    chk("midrun_instret", instret, 0);
    step(3);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_dispatcher.md
Name: control_dispatcher

Overview:
Top-level sequencer of the Control Unit. It takes each decoded instruction (opdecoder `code`), selects which class FSM owns it (load/store, integer ALU, branch/jump, float), and pulses that FSM's `start`. It forwards the selected FSM's control bundle to the DataFlow, waits for that FSM's retire pulse, then counts the retired instruction. Only one FSM drives the datapath at any time. Illegal codes and hung FSMs are trapped.

Parameters:
- N_FSM, 4, number of class FSMs. Index 0 = load/store, 1 = ALU, 2 = branch, 3 = float.
- CTRL_W, 24, width of one FSM control bundle (sel_rd, sel_*, load_*, write_mem, ...).
- MASK0, 32'h0000_2101, code bits claimed by FSM0 (load, store, lui).
- MASK1, 32'h0000_1EFE, code bits claimed by FSM1.
- MASK2, 32'h000F_C000, code bits claimed by FSM2.
- MASK3, 32'hFFF0_0000, code bits claimed by FSM3.
- TIMEOUT, 15, maximum RUN cycles before a hang fault; must be at least 1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- code  in  32  opdecoder one-hot class code, valid while decode_valid=1.
- decode_valid  in  1  instruction register holds a decoded instruction.
- fsm_ctrl  in  N_FSM*CTRL_W  concatenated control bundles; FSM i occupies bits [i*CTRL_W +: CTRL_W].
- fsm_done  in  N_FSM  per-FSM retire pulse (that FSM's load_pc in WRITEBACK).
- fsm_start  out  N_FSM  one-hot start pulse.
- ctrl_out  out  CTRL_W  control bundle to the DataFlow.
- active_id  out  2  index of the granted FSM.
- busy  out  1  high in DISPATCH, RUN and RETIRE.
- retire  out  1  one-cycle pulse per retired instruction.
- illegal  out  1  sticky: no FSM claimed the code.
- timeout_err  out  1  sticky: the granted FSM did not finish in time.
- instret  out  64  retired-instruction counter.

Behaviour:
- Reset (synchronous, wins over everything, including mid-instruction):
  - state = IDLE.
  - fsm_start, ctrl_out, active_id, busy, retire, illegal, timeout_err, instret and the run counter all = 0.
- States: IDLE, DISPATCH, RUN, RETIRE, FAULT.
- IDLE: ctrl_out = 0. If decode_valid=1, latch code and go to DISPATCH. Otherwise stay.
- DISPATCH (1 cycle): compute claim[i] = |(code_q & MASKi).
  - Grant goes to the lowest-index claimant. Register active_id, set fsm_start[grant]=1 for this cycle only, go to RUN.
  - If no FSM claims the code: illegal=1 and go to FAULT. No start pulse is issued.
  - Any fsm_done seen in this cycle is ignored.
- RUN:
  - ctrl_out = fsm_ctrl slice [active_id], combinational mux; non-granted slices are never visible.
  - Run counter starts at 0 on RUN entry and increments each cycle.
  - fsm_done[active_id]=1 takes RUN to RETIRE. done also wins in the cycle the counter equals TIMEOUT-1.
  - Counter reaching TIMEOUT without done: timeout_err=1 and go to FAULT.
  - fsm_done from a non-granted FSM is ignored.
- RETIRE (1 cycle): ctrl_out = 0, retire=1, instret += 1 (wraps modulo 2^64), go to IDLE.
- FAULT: ctrl_out = 0, fsm_start = 0, busy = 0. Held until reset; illegal and timeout_err stay set.
- Latency: decode_valid to fsm_start is 2 cycles. A FSM whose done arrives k cycles after its start pulse retires k+2 cycles after the start pulse.
- decode_valid is sampled only in IDLE. A back-to-back decode_valid is accepted in the IDLE cycle that follows RETIRE.
- fsm_start is never high for more than one cycle and never high for more than one FSM.

Decomposition:
- control_pkg holds:
  - state localparams;
  - FSM index constants FSM_LS, FSM_ALU, FSM_BR, FSM_FP;
  - the default MASKn values;
  - CTRL_W and N_FSM defaults.
- Sub-module: priority_grant, a combinational N-bit lowest-index one-hot and binary encoder with a none_valid flag. All sequencing stays in control_dispatcher.

Test Plan:
- Load dispatch: reset; code=32'h0000_0001, decode_valid=1; FSM0 model asserts done 4 cycles after start → fsm_start=4'b0001 two cycles after decode_valid, ctrl_out equals slice 0 during RUN, retire pulses once, instret=1.
- Priority: code=32'h0000_2002 (bits claimed by FSM0 and FSM1) → fsm_start=4'b0001, active_id=0, FSM1 bundle never appears on ctrl_out.
- Illegal: code=32'h0 with decode_valid=1 → no fsm_start, illegal=1 in the cycle after DISPATCH, ctrl_out=0, later decode_valid ignored until reset.
- Timeout: FSM2 granted (code=32'h0000_4000) and never asserts done → timeout_err=1 after exactly 15 RUN cycles, instret unchanged.
- Spurious done and back-to-back: FSM3 pulses done while FSM1 runs → ignored; FSM1 retires; a second instruction dispatches in the following IDLE cycle; instret=2.
- Reset mid-RUN: assert reset during RUN → next cycle state is IDLE, all outputs 0, instret=0.
